// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path.
//   ps2_state_e  : host transmitter FSM states
//   ERR_*        : err_code values reported with tx_err
//   CMD_*        : common keyboard command bytes
package ps2_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StInhibit,
    StStart,
    StReq,
    StData,
    StParity,
    StStop,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock line conditioner: 2-FF synchronizer, 8-sample stability filter and
// falling-edge detector. Reusable by the receive path.
//   clk, rst_n  : system clock, async active-low reset
//   ps2_clk_i   : raw PS/2 clock pin
//   clk_filt_o  : filtered, synchronized clock level
//   fall_o      : one-cycle pulse on a filtered falling edge
module ps2_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  output logic clk_filt_o,
  output logic fall_o
);

  logic       sync1_q, sync2_q;
  logic [7:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 8'hFF;
      filt_q  <= 1'b1;
    end else begin
      sync1_q <= ps2_clk_i;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[6:0], sync2_q};
      // Level only changes after eight identical samples; otherwise hold.
      if (hist_q == 8'hFF) begin
        filt_q <= 1'b1;
      end else if (hist_q == 8'h00) begin
        filt_q <= 1'b0;
      end
    end
  end

  assign clk_filt_o = filt_q;
  // High for the single cycle in which the filtered level is about to drop.
  assign fall_o     = filt_q & (hist_q == 8'h00);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame and ACK.
//   clk, rst_n          : system clock, async active-low reset
//   PS2_CLK, PS2_DATA   : open-drain lines, driven only 0 or Z
//   tx_data, tx_valid   : command byte and send request
//   tx_ready            : ready to accept a byte
//   busy                : frame in progress (masks the receive decoder)
//   tx_done, tx_err     : one-cycle completion / abort pulses
//   err_code            : abort reason, held until the next error
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 15_000
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned InhW        = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned ToW         = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e     state_q, state_d;
  logic [8:0]     shift_q, shift_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           data_bit_q, data_bit_d;  // bit on PS2_DATA, 1 = released
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           data_s1_q, data_s2_q;

  logic clk_filt, fall;
  logic to_run, timeout;
  logic clk_low, data_low;

  ps2_line_filter u_clk_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (PS2_CLK),
    .clk_filt_o (clk_filt),
    .fall_o     (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      data_bit_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      data_bit_q <= data_bit_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      data_s1_q  <= PS2_DATA;
      data_s2_q  <= data_s1_q;
    end
  end

  assign to_run  = state_q inside {StReq, StData, StParity, StStop, StAck, StWaitIdle};
  assign timeout = to_run && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    data_bit_d = data_bit_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (to_run && (to_cnt_q != ToW'(TIMEOUT_CYC))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        data_bit_d = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_d   = {~^tx_data, tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (inh_cnt_q == InhW'(INHIBIT_CYC - 1)) begin
          state_d = StStart;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      StStart: begin
        to_cnt_d   = '0;
        data_bit_d = 1'b0;  // start bit stays driven once the clock is released
        state_d    = StReq;
      end
      StReq, StData: begin
        if (fall) begin
          data_bit_d = shift_q[0];
          shift_d    = {1'b0, shift_q[8:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          // Count 8 means bit7 is out and this edge drives parity.
          if (state_q == StReq) begin
            state_d = StData;
          end else if (bit_cnt_q == 4'd8) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          data_bit_d = 1'b1;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (fall) begin
          if (!data_s2_q) begin
            state_d = StWaitIdle;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NOACK;
            state_d    = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (clk_filt && data_s2_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout overrides any edge handled above in the same cycle.
    if (timeout) begin
      state_d    = StIdle;
      data_bit_d = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  assign clk_low  = state_q inside {StInhibit, StStart};
  assign data_low = (state_q == StStart) ||
                    ((state_q inside {StReq, StData, StParity}) && !data_bit_q);

  assign PS2_CLK  = clk_low  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_low ? 1'b0 : 1'bz;

  // Ready is withheld during the completion pulse so a new accept lands one cycle later.
  assign tx_ready = (state_q == StIdle) && !done_q && !err_q;
  assign busy     = (state_q != StIdle);
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model clocking at 12.5 kHz
// (1 MHz system clock, 40-cycle half period). A second instance with a short
// timeout is never clocked by a device.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic [1:0] err_code;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  logic [7:0] tx_data_to = 8'h00;
  logic       tx_valid_to = 1'b0;
  logic       tx_ready_to, busy_to, tx_done_to, tx_err_to;
  logic [1:0] err_code_to;
  wire        ps2_clk_to, ps2_data_to;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wide_cnt = 0;
  logic prev_pulse = 1'b0;
  logic ready_after = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  pullup (ps2_clk_to);
  pullup (ps2_data_to);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (10),
    .TIMEOUT_US (15_000)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .err_code (err_code)
  );

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (10),
    .TIMEOUT_US (50)
  ) u_dut_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .PS2_CLK  (ps2_clk_to),
    .PS2_DATA (ps2_data_to),
    .tx_data  (tx_data_to),
    .tx_valid (tx_valid_to),
    .tx_ready (tx_ready_to),
    .busy     (busy_to),
    .tx_done  (tx_done_to),
    .tx_err   (tx_err_to),
    .err_code (err_code_to)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping for the main instance.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (prev_pulse && (tx_done || tx_err)) wide_cnt <= wide_cnt + 1;
    if (prev_pulse) ready_after <= tx_ready;
    prev_pulse <= tx_done || tx_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Waits for request-to-send, then generates n_clk clocks. bits = {stop, parity,
  // d7..d0, start} as sampled on each rising edge. ACK holds DATA low over clocks 11-12.
  task automatic dev_frame(input int n_clk, input bit ack, output logic [10:0] bits);
    int g;
    bits = '1;
    g = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("req_seen", {31'd0, (ps2_clk === 1'b1 && ps2_data === 1'b0)}, 32'd1);
    bits[0] = ps2_data;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= n_clk; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i] = ps2_data;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == 12) dev_data_low = 1'b0;
      if (i != n_clk) repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    int req_cyc, err_cyc, clk_low_cnt, data_fall, d0, e0, g;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Timeout: inhibit 10 + start 1, REQ on cycle 12, error 50 cycles later
    tx_data_to  = 8'hED;
    tx_valid_to = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_to = 1'b0;
    req_cyc = 0;
    err_cyc = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (req_cyc == 0 && ps2_clk_to === 1'b1 && ps2_data_to === 1'b0) req_cyc = k;
      if (err_cyc == 0 && tx_err_to) err_cyc = k;
    end
    check("to_req_cycle", req_cyc, 32'd12);
    check("to_err_delay", err_cyc - req_cyc, 32'd50);
    check("to_err_code", {30'd0, err_code_to}, 32'd1);
    check("to_lines_released", {30'd0, ps2_clk_to, ps2_data_to}, 32'd3);
    check("to_ready", {31'd0, tx_ready_to}, 32'd1);

    // Inhibit timing and 8'hED frame with ACK
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hED);
    clk_low_cnt = 0;
    data_fall = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
      if (ps2_clk === 1'b0) clk_low_cnt++;
      if (data_fall == 0 && ps2_data === 1'b0) data_fall = k;
      if (k == 12) check("clk_released_c12", {31'd0, ps2_clk}, 32'd1);
    end
    check("inhibit_low_cycles", clk_low_cnt, 32'd11);
    check("data_fall_cycle", data_fall, 32'd11);
    dev_frame(12, 1'b1, bits);
    repeat (60) @(negedge clk);
    // ED = 1110_1101 (six ones) -> odd parity 1
    check("frame_ed", {21'd0, bits}, {21'd0, 11'b11_11101101_0});
    check("ed_done_cnt", done_cnt - d0, 32'd1);
    check("ed_err_cnt", err_cnt - e0, 32'd0);
    check("ed_ready_after", {31'd0, ready_after}, 32'd1);

    // No ACK on 8'hEE
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hEE);
    dev_frame(12, 1'b0, bits);
    repeat (20) @(negedge clk);
    check("frame_ee_noack", {21'd0, bits}, {21'd0, 11'b11_11101110_0});
    check("noack_err_cnt", err_cnt - e0, 32'd1);
    check("noack_done_cnt", done_cnt - d0, 32'd0);
    check("noack_code", {30'd0, err_code}, 32'd2);
    check("noack_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    check("noack_ready_after", {31'd0, ready_after}, 32'd1);

    // 8'h00 offered while busy with 8'hFF is dropped
    accept(8'hFF);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(12, 1'b1, bits);
    check("frame_ff", {21'd0, bits}, {21'd0, 11'b11_11111111_0});
    g = 0;
    while (!tx_done && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ff_done_seen", {31'd0, tx_done}, 32'd1);
    check("pulse_ready_low", {31'd0, tx_ready}, 32'd0);
    // Back-to-back 8'hEE: held valid from the pulse cycle, accepted the cycle after
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_clk_low", {31'd0, ps2_clk}, 32'd0);
    d0 = done_cnt;
    dev_frame(12, 1'b1, bits);
    repeat (60) @(negedge clk);
    check("frame_ee_b2b", {21'd0, bits}, {21'd0, 11'b11_11101110_0});
    check("b2b_done_cnt", done_cnt - d0, 32'd1);

    // Reset in the middle of DATA (bit4 = 0 on the wire)
    accept(8'hED);
    dev_frame(5, 1'b0, bits);
    check("pre_rst_data_low", {31'd0, ps2_data}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'hED);
    dev_frame(12, 1'b1, bits);
    repeat (60) @(negedge clk);
    check("frame_ed_after_rst", {21'd0, bits}, {21'd0, 11'b11_11101101_0});
    check("post_rst_done_cnt", done_cnt - d0, 32'd1);
    check("post_rst_err_cnt", err_cnt - e0, 32'd0);
    check("pulse_width", wide_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
